// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
// Shared constants and types for the instruction fetch unit.
//   ISA_WIDTH : width of PC, fetch address and instruction word
//   RESET_PC  : architectural PC after reset
//   PC_STEP   : sequential PC increment in bytes
//   state_t   : fetch FSM state encoding (2 bits)
//   align_pc  : clears the byte-offset bits of a redirect target
package ifu_fetch_pkg;

    localparam int ISA_WIDTH = 32;
    localparam logic [ISA_WIDTH-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [ISA_WIDTH-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [ISA_WIDTH-1:0] align_pc(input logic [ISA_WIDTH-1:0] target);
        return {target[ISA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_out_buf.sv
// ifu_out_buf
// One-entry valid/ready holding register between fetch and decode.
//   clk, reset          : clock, asynchronous active-low reset
//   flush               : drop the buffered entry (wins over load)
//   load                : capture load_inst/load_pc and raise out_valid
//   load_inst, load_pc  : instruction word and its PC to capture
//   out_ready           : downstream accepts the entry
//   out_valid           : entry available
//   out_inst, out_pc    : buffered instruction and PC, stable while stalled
module ifu_out_buf
    import ifu_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 load,
    input  logic [ISA_WIDTH-1:0] load_inst,
    input  logic [ISA_WIDTH-1:0] load_pc,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ISA_WIDTH-1:0] out_inst,
    output logic [ISA_WIDTH-1:0] out_pc
);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= RESET_PC;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_inst  <= load_inst;
            out_pc    <= load_pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch
// Instruction fetch unit: owns the PC, issues one SRAM read at a time,
// buffers the response and hands it to decode over valid/ready. Redirects
// from execute override sequential fetch and squash in-flight or buffered
// instructions.
//   clk, reset                : clock, asynchronous active-low reset
//   mem_ren, mem_raddr        : SRAM read request pulse and address (= pc)
//   mem_valid, mem_rdata      : SRAM response valid and instruction word
//   mem_pc                    : SRAM echo of the address that was read
//   redirect_valid/_pc        : control-flow redirect and its target
//   out_valid/ready/inst/pc   : decode handshake and payload
//   fetch_err                 : sticky, an accepted response echoed a wrong PC
module ifu_fetch
    import ifu_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_ren,
    output logic [ISA_WIDTH-1:0] mem_raddr,
    input  logic                 mem_valid,
    input  logic [ISA_WIDTH-1:0] mem_rdata,
    input  logic [ISA_WIDTH-1:0] mem_pc,
    input  logic                 redirect_valid,
    input  logic [ISA_WIDTH-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ISA_WIDTH-1:0] out_inst,
    output logic [ISA_WIDTH-1:0] out_pc,
    output logic                 fetch_err
);

    state_t               state;
    logic [ISA_WIDTH-1:0] pc;
    logic                 kill;     // outstanding response belongs to a squashed fetch
    logic                 accept;
    logic                 flush_buf;

    assign mem_raddr = pc;

    // A response is kept only if no redirect arrived while it was in flight
    // and none is arriving in the same cycle.
    assign accept    = (state == S_WAIT) && mem_valid && !kill && !redirect_valid;
    assign flush_buf = (state == S_HOLD) && redirect_valid;

    // The next request leaves in the same cycle decode takes the buffered
    // instruction, giving one instruction per two cycles with a 1-cycle SRAM.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_ren = 1'b0;
        case (state)
            S_REQ:   mem_ren = !redirect_valid;
            S_HOLD:  mem_ren = !redirect_valid && out_ready;
            default: mem_ren = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;

                S_REQ: begin
                    if (redirect_valid) pc <= align_pc(redirect_pc);
                    else                state <= S_WAIT;
                end

                S_WAIT: begin
                    if (redirect_valid) pc <= align_pc(redirect_pc);
                    if (mem_valid) begin
                        if (kill || redirect_valid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            pc    <= pc + PC_STEP;
                            state <= S_HOLD;
                            if (mem_pc != pc) fetch_err <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        // Response still pending: remember to drop it.
                        kill <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= align_pc(redirect_pc);
                        state <= S_REQ;
                    end else if (out_ready) begin
                        state <= S_WAIT;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    ifu_out_buf u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_buf),
        .load      (accept),
        .load_inst (mem_rdata),
        .load_pc   (pc),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
// Self-checking bench for ifu_fetch. A behavioural SRAM answers each request
// after a configurable latency. The reference model tracks only the next
// program-order PC that decode should see: it advances by 4 on every
// handshake and jumps to the aligned target on every redirect. Every request
// address and every delivered instruction is compared against it, plus
// directed timing checks for the listed scenarios and a randomized run.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic [31:0] mem_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fetch_err;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_valid      (mem_valid),
        .mem_rdata      (mem_rdata),
        .mem_pc         (mem_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fetch_err      (fetch_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // SRAM model
    bit          sram_pending;
    int          sram_cnt;
    logic [31:0] sram_addr;
    int          sram_lat;
    bit          sram_rand_lat;
    bit          corrupt_next;

    // Reference model and observation history
    logic [31:0] exp_pc;
    logic [31:0] deliv_q[$];
    bit          prev_stall;
    logic [31:0] prev_inst, prev_pc;
    int          cyc;
    int          ren_cnt;
    logic        last_ren, last_out_valid, last_err;
    logic [31:0] last_raddr, last_out_pc;
    logic        ren_log[0:15];
    logic        ov_log[0:15];
    logic [31:0] raddr_log[0:15];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered and left at posedge+1. Drives one cycle of stimulus, samples at
    // the falling edge and runs the model checks for that cycle.
    task run_cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        mem_valid      = 1'b0;
        mem_rdata      = $urandom;
        mem_pc         = $urandom;
        if (sram_pending) begin
            if (sram_cnt <= 1) begin
                mem_valid    = 1'b1;
                mem_rdata    = mem_word(sram_addr);
                mem_pc       = corrupt_next ? 32'h0 : sram_addr;
                corrupt_next = 1'b0;
                sram_pending = 1'b0;
            end else begin
                sram_cnt--;
            end
        end

        @(negedge clk);
        cyc++;
        last_ren       = mem_ren;
        last_raddr     = mem_raddr;
        last_out_valid = out_valid;
        last_out_pc    = out_pc;
        last_err       = fetch_err;
        if (mem_ren === 1'b1) ren_cnt++;
        if (cyc < 16) begin
            ren_log[cyc]   = mem_ren;
            ov_log[cyc]    = out_valid;
            raddr_log[cyc] = mem_raddr;
        end

        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_inst", out_inst, prev_inst);
            check("stall_pc", out_pc, prev_pc);
        end
        if (out_valid === 1'b1 && !rdy) check("stall_no_req", mem_ren, 0);

        if (redir) begin
            check("redir_no_req", mem_ren, 0);
            exp_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (out_valid === 1'b1 && rdy) begin
                check("deliv_pc", out_pc, exp_pc);
                check("deliv_inst", out_inst, mem_word(exp_pc));
                deliv_q.push_back(out_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (mem_ren === 1'b1) begin
                check("req_addr", mem_raddr, exp_pc);
                check("one_outstanding", sram_pending, 0);
                sram_pending = 1'b1;
                sram_cnt     = sram_rand_lat ? int'($urandom_range(1, 4)) : sram_lat;
                sram_addr    = mem_raddr;
            end
        end

        prev_stall = (out_valid === 1'b1) && !rdy && !redir;
        prev_inst  = out_inst;
        prev_pc    = out_pc;

        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; asserts reset mid-cycle, checks the reset values,
    // releases at posedge+1. With stray set, a leftover SRAM response shows up
    // in the first cycle after release.
    task do_reset(input bit stray);
        #2;
        reset          = 1'b0;
        mem_valid      = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_raddr", mem_raddr, 32'h8000_0000);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc", out_pc, 32'h8000_0000);
        check("rst_fetch_err", fetch_err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        sram_pending = stray;
        sram_cnt     = 1;
        sram_addr    = 32'h1234_5670;
        corrupt_next = 1'b0;
        exp_pc       = 32'h8000_0000;
        prev_stall   = 1'b0;
        cyc          = 0;
        reset        = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int iters;
        int ren_before;
        int nd_before;

        reset          = 1'b1;
        mem_valid      = 1'b0;
        mem_rdata      = '0;
        mem_pc         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        sram_lat       = 1;
        sram_rand_lat  = 1'b0;
        ren_cnt        = 0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // 1: sequential fetch, 1-cycle SRAM, decode always ready
        repeat (7) run_cycle(1'b1, 1'b0, 32'h0);
        for (int i = 1; i <= 6; i++)
            check($sformatf("t1_ren_c%0d", i), ren_log[i], (i % 2 == 0) ? 1 : 0);
        check("t1_addr_c2", raddr_log[2], 32'h8000_0000);
        check("t1_addr_c4", raddr_log[4], 32'h8000_0004);
        check("t1_addr_c6", raddr_log[6], 32'h8000_0008);
        check("t1_first_valid_c4", ov_log[4], 1);
        check("t1_deliv_cnt", deliv_q.size(), 2);
        check("t1_last_deliv", deliv_q[$], 32'h8000_0004);

        // 2: decode stalls for 5 cycles while an instruction is buffered
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0);
            found = last_out_valid;
        end
        check("t2_valid_seen", found, 1);
        ren_before = ren_cnt;
        repeat (4) run_cycle(1'b0, 1'b0, 32'h0);
        check("t2_no_req_stalled", ren_cnt - ren_before, 0);
        run_cycle(1'b1, 1'b0, 32'h0);
        check("t2_req_on_ready", last_ren, 1);
        check("t2_req_addr", last_raddr, 32'h8000_000C);
        check("t2_deliv", deliv_q[$], 32'h8000_0008);

        // 3: redirect while holding, beats out_ready
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0);
            found = last_out_valid;
        end
        check("t3_valid_seen", found, 1);
        nd_before = deliv_q.size();
        run_cycle(1'b1, 1'b1, 32'h8000_0103);
        run_cycle(1'b1, 1'b0, 32'h0);
        check("t3_gap1", last_out_valid, 0);
        check("t3_req", last_ren, 1);
        check("t3_req_addr", last_raddr, 32'h8000_0100);
        run_cycle(1'b1, 1'b0, 32'h0);
        check("t3_gap2", last_out_valid, 0);
        sram_lat = 3;
        run_cycle(1'b1, 1'b0, 32'h0);
        check("t3_valid_back", last_out_valid, 1);
        check("t3_out_pc", last_out_pc, 32'h8000_0100);
        check("t3_deliv_cnt", deliv_q.size() - nd_before, 1);

        // 4: 3-cycle SRAM, redirect one cycle after the request
        run_cycle(1'b1, 1'b1, 32'h8000_1000);
        ren_before = ren_cnt;
        found = 1'b0;
        iters = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            run_cycle(1'b1, 1'b0, 32'h0);
            iters++;
            found = last_out_valid;
        end
        check("t4_valid_seen", found, 1);
        check("t4_first_pc", last_out_pc, 32'h8000_1000);
        check("t4_latency", iters, 7);
        check("t4_req_cnt", ren_cnt - ren_before, 2);
        sram_lat = 1;

        // 5: SRAM echoes a wrong PC once; fetch_err is sticky
        check("t5_err_before", last_err, 0);
        corrupt_next = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            run_cycle(1'b1, 1'b0, 32'h0);
            found = last_out_valid;
        end
        check("t5_valid_seen", found, 1);
        check("t5_err_set", last_err, 1);
        check("t5_bad_pc_inst", last_out_pc, 32'h8000_1004);
        run_cycle(1'b1, 1'b1, 32'h8000_2000);
        repeat (6) run_cycle(1'b1, 1'b0, 32'h0);
        check("t5_err_sticky", last_err, 1);

        // 6: reset while waiting on the SRAM, stray response after release
        sram_lat = 3;
        run_cycle(1'b1, 1'b1, 32'h8000_3000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            run_cycle(1'b1, 1'b0, 32'h0);
            found = last_ren;
        end
        check("t6_req_seen", found, 1);
        run_cycle(1'b0, 1'b0, 32'h0);
        do_reset(1'b1);
        sram_lat = 1;
        repeat (4) run_cycle(1'b1, 1'b0, 32'h0);
        check("t6_ov_c1", ov_log[1], 0);
        check("t6_ov_c2", ov_log[2], 0);
        check("t6_ov_c3", ov_log[3], 0);
        check("t6_ren_c2", ren_log[2], 1);
        check("t6_addr_c2", raddr_log[2], 32'h8000_0000);
        check("t6_ov_c4", ov_log[4], 1);
        check("t6_err_cleared", last_err, 0);

        // 7: unaligned redirect near the top of the address space wraps to 0
        run_cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
        nd_before = deliv_q.size();
        for (int i = 0; i < 12 && deliv_q.size() < nd_before + 2; i++)
            run_cycle(1'b1, 1'b0, 32'h0);
        check("t7_deliv_cnt", deliv_q.size() - nd_before, 2);
        if (deliv_q.size() >= nd_before + 2) begin
            check("t7_top", deliv_q[nd_before], 32'hFFFF_FFFC);
            check("t7_wrap", deliv_q[nd_before + 1], 32'h0000_0000);
        end

        // Randomized run: random stalls, redirects and SRAM latency 1..4
        do_reset(1'b0);
        sram_rand_lat = 1'b1;
        nd_before = deliv_q.size();
        repeat (3) run_cycle(1'b1, 1'b0, 32'h0);
        repeat (2000) begin
            bit          rdy, redir;
            logic [31:0] tgt;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
            run_cycle(rdy, redir, tgt);
        end
        check("rand_progress", (deliv_q.size() - nd_before > 100) ? 1 : 0, 1);
        check("rand_no_err", last_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
